// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment receive path: common-cathode patterns,
// decoded code values, digit slots and the capture FSM states.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [3:0] CODE_BLANK = 4'hE;
  localparam logic [3:0] CODE_BAD   = 4'hF;

  typedef enum logic [1:0] {D1 = 2'd0, D10 = 2'd1, D100 = 2'd2, D1000 = 2'd3} slot_e;
  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, HOLD = 2'd2} state_e;

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Only meaningful for a one-hot enable vector.
  function automatic slot_e slot_of(input logic [3:0] en);
    case (en)
      4'b0001: return D1;
      4'b0010: return D10;
      4'b0100: return D100;
      default: return D1000;
    endcase
  endfunction

  // Scan runs d1 -> d10 -> d100 -> d1000 -> d1.
  function automatic slot_e next_slot(input slot_e s);
    logic [1:0] n;
    n = s + 2'd1;
    return slot_e'(n);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Common-cathode segment pattern (bit6=a .. bit0=g) to digit code; blank maps
// to CODE_BLANK and anything unrecognised to CODE_BAD.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic [3:0] code_o
);

  always_comb begin
    case (pattern_i)
      SEG_0:     code_o = 4'd0;
      SEG_1:     code_o = 4'd1;
      SEG_2:     code_o = 4'd2;
      SEG_3:     code_o = 4'd3;
      SEG_4:     code_o = 4'd4;
      SEG_5:     code_o = 4'd5;
      SEG_6:     code_o = 4'd6;
      SEG_7:     code_o = 4'd7;
      SEG_8:     code_o = 4'd8;
      SEG_9:     code_o = 4'd9;
      SEG_BLANK: code_o = CODE_BLANK;
      default:   code_o = CODE_BAD;
    endcase
  end

endmodule

// File: rtl/segment2digit.sv
// Rebuilds the four BCD digits shown on a multiplexed common-cathode display by
// sampling the shared segment bus per enable and publishing whole scan frames.
module segment2digit #(
  parameter int SETTLE      = 4,
  parameter int TIMEOUT     = 1_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] segmentShow,
  input  logic       dp,
  input  logic       segment1,
  input  logic       segment2,
  input  logic       segment3,
  input  logic       segment4,
  output logic [3:0] digit,
  output logic [3:0] ten,
  output logic [3:0] hundred,
  output logic [3:0] thousand,
  output logic [3:0] dp_mask,
  output logic       frame_valid,
  output logic       frame_pulse,
  output logic       scan_error,
  output logic       stale
);
  import seg7_pkg::*;

  localparam int CW = $clog2(SETTLE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [11:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {segment4, segment3, segment2, segment1, dp, segmentShow};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  logic [6:0] seg_s;
  logic       dp_s;
  logic [3:0] en_s;
  logic [3:0] code_s;
  assign seg_s = sync_q[SYNC_STAGES-1][6:0];
  assign dp_s  = sync_q[SYNC_STAGES-1][7];
  assign en_s  = sync_q[SYNC_STAGES-1][11:8];

  seg7_decode u_decode (.pattern_i(seg_s), .code_o(code_s));

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      cur_en_q, cur_en_d, en_prev_q;
  logic [3:0]      mask_q, mask_d;
  slot_e           last_slot_q, last_slot_d, cap_slot;
  logic [3:0][3:0] shadow_q, shadow_d, out_q, out_d;
  logic [3:0]      sdp_q, sdp_d, dp_mask_q, dp_mask_d;
  logic            frame_valid_q, frame_valid_d, frame_pulse_q, frame_pulse_d;
  logic            scan_error_q, scan_error_d, stale_q, stale_d;
  logic [TW-1:0]   stale_cnt_q, stale_cnt_d;
  logic            en_change, en_illegal, err_en, timeout_hit, timed_out, settled;

  assign en_change   = (en_s != en_prev_q);
  assign en_illegal  = (en_s != 4'd0) && !is_onehot(en_s);
  // Only the entry into an illegal enable vector is reported, not every cycle of it.
  assign err_en      = en_illegal && !((en_prev_q != 4'd0) && !is_onehot(en_prev_q));
  assign timeout_hit = !en_change && (stale_cnt_q == TW'(TIMEOUT - 1));
  assign timed_out   = !en_change && (stale_cnt_q == TW'(TIMEOUT));
  assign cap_slot    = slot_of(en_s);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cur_en_d      = cur_en_q;
    mask_d        = mask_q;
    last_slot_d   = last_slot_q;
    shadow_d      = shadow_q;
    sdp_d         = sdp_q;
    out_d         = out_q;
    dp_mask_d     = dp_mask_q;
    frame_valid_d = frame_valid_q;
    frame_pulse_d = 1'b0;
    scan_error_d  = 1'b0;
    stale_d       = stale_q;
    settled       = 1'b0;

    if (en_change)                        stale_cnt_d = '0;
    else if (stale_cnt_q != TW'(TIMEOUT)) stale_cnt_d = stale_cnt_q + TW'(1);
    else                                  stale_cnt_d = stale_cnt_q;

    case (state_q)
      IDLE: begin
        if (is_onehot(en_s)) begin
          state_d  = seg7_pkg::SETTLE;
          cnt_d    = CW'(SETTLE);
          cur_en_d = en_s;
        end
      end
      seg7_pkg::SETTLE, HOLD: begin
        if (en_s != cur_en_q) begin
          if (is_onehot(en_s)) begin
            state_d  = seg7_pkg::SETTLE;
            cnt_d    = CW'(SETTLE);
            cur_en_d = en_s;
          end else begin
            state_d = IDLE;
          end
        end else if (state_q == seg7_pkg::SETTLE) begin
          if (cnt_q == CW'(1)) begin
            settled = 1'b1;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Priority: timeout, then illegal enables, then capture, then commit.
    if (timeout_hit || timed_out) begin
      state_d       = IDLE;
      mask_d        = '0;
      stale_d       = 1'b1;
      frame_valid_d = 1'b0;
    end else if (err_en) begin
      state_d      = IDLE;
      mask_d       = '0;
      scan_error_d = 1'b1;
    end else if (settled) begin
      shadow_d[cap_slot] = code_s;
      sdp_d[cap_slot]    = dp_s;
      last_slot_d        = cap_slot;
      if (mask_q != 4'd0 && cap_slot != next_slot(last_slot_q)) begin
        scan_error_d = 1'b1;
        mask_d       = 4'd1 << cap_slot;
      end else begin
        mask_d = mask_q | (4'd1 << cap_slot);
      end
    end else if (mask_q == 4'hF) begin
      out_d         = shadow_q;
      dp_mask_d     = sdp_q;
      frame_pulse_d = 1'b1;
      frame_valid_d = 1'b1;
      for (int i = 0; i < 4; i++) if (shadow_q[i] == CODE_BAD) frame_valid_d = 1'b0;
      mask_d        = '0;
      stale_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      cur_en_q      <= '0;
      en_prev_q     <= '0;
      mask_q        <= '0;
      last_slot_q   <= D1;
      shadow_q      <= '0;
      sdp_q         <= '0;
      out_q         <= {4{CODE_BAD}};
      dp_mask_q     <= '0;
      frame_valid_q <= 1'b0;
      frame_pulse_q <= 1'b0;
      scan_error_q  <= 1'b0;
      stale_q       <= 1'b1;
      stale_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cur_en_q      <= cur_en_d;
      en_prev_q     <= en_s;
      mask_q        <= mask_d;
      last_slot_q   <= last_slot_d;
      shadow_q      <= shadow_d;
      sdp_q         <= sdp_d;
      out_q         <= out_d;
      dp_mask_q     <= dp_mask_d;
      frame_valid_q <= frame_valid_d;
      frame_pulse_q <= frame_pulse_d;
      scan_error_q  <= scan_error_d;
      stale_q       <= stale_d;
      stale_cnt_q   <= stale_cnt_d;
    end
  end

  assign digit       = out_q[D1];
  assign ten         = out_q[D10];
  assign hundred     = out_q[D100];
  assign thousand    = out_q[D1000];
  assign dp_mask     = dp_mask_q;
  assign frame_valid = frame_valid_q;
  assign frame_pulse = frame_pulse_q;
  assign scan_error  = scan_error_q;
  assign stale       = stale_q;

endmodule

// File: tb/tb_segment2digit.sv
// Directed bench for segment2digit: scans the display bus like the driver would
// and checks committed digits, strobes and the stale timer.
module tb_segment2digit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] segmentShow;
  logic       dp, segment1, segment2, segment3, segment4;
  logic [3:0] digit, ten, hundred, thousand, dp_mask;
  logic       frame_valid, frame_pulse, scan_error, stale;

  int checks = 0;
  int failures = 0;
  int pulse_cnt = 0;
  int err_cnt = 0;

  always #10 clk = ~clk;

  segment2digit #(.SETTLE(4), .TIMEOUT(200), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .segmentShow(segmentShow), .dp(dp),
    .segment1(segment1), .segment2(segment2), .segment3(segment3), .segment4(segment4),
    .digit(digit), .ten(ten), .hundred(hundred), .thousand(thousand), .dp_mask(dp_mask),
    .frame_valid(frame_valid), .frame_pulse(frame_pulse), .scan_error(scan_error), .stale(stale)
  );

  always @(negedge clk) begin
    if (frame_pulse === 1'b1) pulse_cnt++;
    if (scan_error === 1'b1) err_cnt++;
  end

  // Hand-written common-cathode patterns, bit6=a .. bit0=g.
  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic show(input logic [3:0] en, input logic [6:0] p, input logic d, input int hold, input int gap);
    {segment4, segment3, segment2, segment1} = en;
    segmentShow = p;
    dp = d;
    tick(hold);
    {segment4, segment3, segment2, segment1} = 4'b0000;
    segmentShow = 7'b0000000;
    dp = 1'b0;
    tick(gap);
  endtask

  task automatic scan4(input logic [6:0] p1, input logic [6:0] p10, input logic [6:0] p100,
                       input logic [6:0] p1000, input logic [3:0] dpm);
    show(4'b0001, p1, dpm[0], 20, 2);
    show(4'b0010, p10, dpm[1], 20, 2);
    show(4'b0100, p100, dpm[2], 20, 2);
    show(4'b1000, p1000, dpm[3], 20, 2);
    tick(6);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    segmentShow = 7'b0; dp = 1'b0;
    {segment4, segment3, segment2, segment1} = 4'b0000;
    tick(3);
    checks++;
    if ({digit, ten, hundred, thousand, dp_mask, frame_valid, frame_pulse, scan_error, stale} !== 24'hFFFF01) begin
      failures++;
      $display("FAIL reset_state got=%h exp=ffff01",
               {digit, ten, hundred, thousand, dp_mask, frame_valid, frame_pulse, scan_error, stale});
    end
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_basic_1234();
    int p0, e0;
    p0 = pulse_cnt; e0 = err_cnt;
    scan4(pat(4), pat(3), pat(2), pat(1), 4'b0000);
    checks++; if (pulse_cnt - p0 !== 1) begin failures++; $display("FAIL basic_pulses got=%0d exp=1", pulse_cnt - p0); end
    checks++; if (err_cnt - e0 !== 0) begin failures++; $display("FAIL basic_errors got=%0d exp=0", err_cnt - e0); end
    checks++; if ({thousand, hundred, ten, digit} !== 16'h1234) begin failures++; $display("FAIL basic_digits got=%h exp=1234", {thousand, hundred, ten, digit}); end
    checks++; if ({frame_valid, stale, dp_mask} !== 6'b10_0000) begin failures++; $display("FAIL basic_flags got=%b exp=100000", {frame_valid, stale, dp_mask}); end
  endtask

  task automatic test_short_enables();
    int p0;
    p0 = pulse_cnt;
    show(4'b0001, pat(8), 1'b0, 3, 2);
    show(4'b0010, pat(8), 1'b0, 3, 2);
    show(4'b0100, pat(8), 1'b0, 3, 2);
    show(4'b1000, pat(8), 1'b0, 3, 2);
    tick(6);
    checks++; if (pulse_cnt - p0 !== 0) begin failures++; $display("FAIL short_no_pulse got=%0d exp=0", pulse_cnt - p0); end
    checks++; if ({thousand, hundred, ten, digit} !== 16'h1234) begin failures++; $display("FAIL short_hold got=%h exp=1234", {thousand, hundred, ten, digit}); end
    scan4(pat(7), pat(7), pat(7), pat(7), 4'b0000);
    checks++; if (pulse_cnt - p0 !== 1) begin failures++; $display("FAIL sevens_pulse got=%0d exp=1", pulse_cnt - p0); end
    checks++; if ({thousand, hundred, ten, digit} !== 16'h7777) begin failures++; $display("FAIL sevens_digits got=%h exp=7777", {thousand, hundred, ten, digit}); end
  endtask

  task automatic test_illegal_enable();
    int p0, e0;
    p0 = pulse_cnt; e0 = err_cnt;
    show(4'b0001, pat(9), 1'b0, 20, 2);
    show(4'b0010, pat(9), 1'b0, 20, 2);
    show(4'b0011, pat(9), 1'b0, 10, 4);
    checks++; if (err_cnt - e0 !== 1) begin failures++; $display("FAIL illegal_err got=%0d exp=1", err_cnt - e0); end
    checks++; if (pulse_cnt - p0 !== 0) begin failures++; $display("FAIL illegal_no_pulse got=%0d exp=0", pulse_cnt - p0); end
    scan4(pat(8), pat(7), pat(6), pat(5), 4'b0000);
    checks++; if (pulse_cnt - p0 !== 1) begin failures++; $display("FAIL illegal_recover_pulse got=%0d exp=1", pulse_cnt - p0); end
    checks++; if ({thousand, hundred, ten, digit} !== 16'h5678) begin failures++; $display("FAIL illegal_recover_digits got=%h exp=5678", {thousand, hundred, ten, digit}); end
  endtask

  task automatic test_order_error();
    int p0, e0;
    p0 = pulse_cnt; e0 = err_cnt;
    show(4'b0001, pat(1), 1'b0, 20, 2);
    show(4'b0100, pat(2), 1'b0, 20, 2);
    checks++; if (err_cnt - e0 !== 1) begin failures++; $display("FAIL order_err got=%0d exp=1", err_cnt - e0); end
    show(4'b1000, pat(3), 1'b0, 20, 2);
    show(4'b0001, pat(4), 1'b0, 20, 2);
    show(4'b0010, pat(5), 1'b0, 20, 2);
    tick(6);
    checks++; if (pulse_cnt - p0 !== 1) begin failures++; $display("FAIL order_pulse got=%0d exp=1", pulse_cnt - p0); end
    checks++; if (err_cnt - e0 !== 1) begin failures++; $display("FAIL order_err_total got=%0d exp=1", err_cnt - e0); end
    checks++; if ({thousand, hundred, ten, digit} !== 16'h3254) begin failures++; $display("FAIL order_digits got=%h exp=3254", {thousand, hundred, ten, digit}); end
  endtask

  task automatic test_bad_pattern();
    int p0;
    p0 = pulse_cnt;
    scan4(7'b0000000, 7'b1010101, pat(8), pat(0), 4'b0100);
    checks++; if (pulse_cnt - p0 !== 1) begin failures++; $display("FAIL badpat_pulse got=%0d exp=1", pulse_cnt - p0); end
    checks++; if ({thousand, hundred, ten, digit} !== 16'h08FE) begin failures++; $display("FAIL badpat_digits got=%h exp=08fe", {thousand, hundred, ten, digit}); end
    checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL badpat_valid got=%b exp=0", frame_valid); end
    checks++; if (dp_mask !== 4'b0100) begin failures++; $display("FAIL badpat_dp_mask got=%b exp=0100", dp_mask); end
  endtask

  task automatic test_stale();
    int p0, n;
    p0 = pulse_cnt;
    scan4(pat(0), pat(9), pat(0), pat(9), 4'b0000);
    checks++; if ({frame_valid, stale, thousand, hundred, ten, digit} !== 18'b10_1001_0000_1001_0000) begin
      failures++; $display("FAIL prestale got=%b exp=101001000010010000", {frame_valid, stale, thousand, hundred, ten, digit}); end
    n = 0;
    while (stale !== 1'b1 && n < 400) begin
      tick(1);
      n++;
    end
    // Last enable change seen 8 cycles before the wait; TIMEOUT=200 puts the rise near n=195.
    checks++; if (n < 190 || n > 200) begin failures++; $display("FAIL stale_timing got=%0d exp=190..200", n); end
    checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL stale_valid got=%b exp=0", frame_valid); end
    checks++; if ({thousand, hundred, ten, digit} !== 16'h9090) begin failures++; $display("FAIL stale_hold got=%h exp=9090", {thousand, hundred, ten, digit}); end
    scan4(pat(8), pat(6), pat(4), pat(2), 4'b0000);
    checks++; if (pulse_cnt - p0 !== 2) begin failures++; $display("FAIL unstale_pulses got=%0d exp=2", pulse_cnt - p0); end
    checks++; if ({stale, frame_valid, thousand, hundred, ten, digit} !== 18'b01_0010_0100_0110_1000) begin
      failures++; $display("FAIL unstale got=%b exp=010010010001101000", {stale, frame_valid, thousand, hundred, ten, digit}); end
  endtask

  task automatic test_reset_midframe();
    int p0;
    show(4'b0001, pat(3), 1'b0, 20, 2);
    show(4'b0010, pat(3), 1'b0, 20, 2);
    {segment4, segment3, segment2, segment1} = 4'b0100;
    segmentShow = pat(3);
    tick(4);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({digit, ten, hundred, thousand, dp_mask, frame_valid, frame_pulse, scan_error, stale} !== 24'hFFFF01) begin
      failures++;
      $display("FAIL midreset_state got=%h exp=ffff01",
               {digit, ten, hundred, thousand, dp_mask, frame_valid, frame_pulse, scan_error, stale});
    end
    {segment4, segment3, segment2, segment1} = 4'b0000;
    segmentShow = 7'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    p0 = pulse_cnt;
    show(4'b0001, pat(6), 1'b0, 20, 2);
    show(4'b0010, pat(6), 1'b0, 20, 2);
    show(4'b0100, pat(6), 1'b0, 20, 2);
    tick(6);
    checks++; if (pulse_cnt - p0 !== 0) begin failures++; $display("FAIL partial_no_pulse got=%0d exp=0", pulse_cnt - p0); end
    show(4'b1000, pat(6), 1'b0, 20, 2);
    tick(6);
    checks++; if (pulse_cnt - p0 !== 1) begin failures++; $display("FAIL postreset_pulse got=%0d exp=1", pulse_cnt - p0); end
    checks++; if ({stale, frame_valid, thousand, hundred, ten, digit} !== 18'b01_0110_0110_0110_0110) begin
      failures++; $display("FAIL postreset got=%b exp=010110011001100110", {stale, frame_valid, thousand, hundred, ten, digit}); end
  endtask

  initial begin
    test_reset();
    test_basic_1234();
    test_short_enables();
    test_illegal_enable();
    test_order_error();
    test_bad_pattern();
    test_stale();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
